key_rst_gen: RTL and testbench

//  Parametrised key-combo reset generator. It replaces the plain key-to-rst_n decode.

---
 rtl/key_rst_gen.sv | 140 ++++++++++++++
 tb/tb_key_rst_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_rst_gen.sv
// Key-combo reset generator: per-key sync and debounce, then a held combo fires a stretched,
// synchronously released active-low reset pulse. Reset itself replays the full pulse.
module key_rst_gen #(
    parameter int unsigned           NUM_KEYS     = 4,
    parameter int unsigned           DEBOUNCE_CYC = 240000,
    parameter int unsigned           HOLD_CYC     = 12000000,
    parameter int unsigned           STRETCH_CYC  = 16,
    parameter logic [NUM_KEYS-1:0]   COMBO_MASK   = '1,
    parameter int unsigned           MODE         = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_db,
    output logic                sw_rst_n,
    output logic                fire_pulse,
    output logic                busy
);

    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned HO_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int unsigned ST_W = (STRETCH_CYC > 1) ? $clog2(STRETCH_CYC) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLD_CYC - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYC - 1);

    typedef enum logic [1:0] {StIdle, StArm, StFire, StWaitRel} state_e;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];
    logic [DB_W-1:0]     db_cnt_d [NUM_KEYS];

    state_e          state_q, state_d;
    logic [HO_W-1:0] hold_q, hold_d;
    logic [ST_W-1:0] stretch_q, stretch_d;
    logic            sw_rst_n_q, sw_rst_n_d;
    logic            fire_q, fire_d;
    logic            trig, any_held;

    // Sync flops and stable level reset to "released" so no key reads as pressed out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign key_db   = ~stable_q;
    assign any_held = |(key_db & COMBO_MASK);
    assign trig     = (MODE != 0) ? &(key_db | ~COMBO_MASK) : any_held;

    // Reset lands in StFire so the stretched pulse is replayed after every rst_n release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFire;
            hold_q     <= '0;
            stretch_q  <= '0;
            sw_rst_n_q <= 1'b0;
            fire_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            stretch_q  <= stretch_d;
            sw_rst_n_q <= sw_rst_n_d;
            fire_q     <= fire_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stretch_d = stretch_q;
        fire_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (trig) begin
                    hold_d  = '0;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (!trig) begin
                    state_d = StIdle;
                end else if (hold_q == HO_LAST) begin
                    state_d   = StFire;
                    fire_d    = 1'b1;
                    stretch_d = '0;
                end else begin
                    hold_d = hold_q + HO_W'(1);
                end
            end
            StFire: begin
                if (stretch_q == ST_LAST) begin
                    state_d = StWaitRel;
                end else begin
                    stretch_d = stretch_q + ST_W'(1);
                end
            end
            StWaitRel: begin
                if (!any_held) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        sw_rst_n_d = (state_d != StFire);
    end

    assign sw_rst_n   = sw_rst_n_q;
    assign fire_pulse = fire_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_key_rst_gen.sv
// Directed bench for key_rst_gen: a MODE=1 and a MODE=0 instance share clock, reset and keys.
module tb_key_rst_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'b1111;
    logic [3:0] key_db1, key_db0;
    logic       sw1, sw0, fp1, fp0, busy1, busy0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    key_rst_gen #(
        .NUM_KEYS(4), .DEBOUNCE_CYC(4), .HOLD_CYC(8), .STRETCH_CYC(3),
        .COMBO_MASK(4'b0011), .MODE(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_db(key_db1),
        .sw_rst_n(sw1), .fire_pulse(fp1), .busy(busy1)
    );

    key_rst_gen #(
        .NUM_KEYS(4), .DEBOUNCE_CYC(4), .HOLD_CYC(8), .STRETCH_CYC(3),
        .COMBO_MASK(4'b0011), .MODE(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_db(key_db0),
        .sw_rst_n(sw0), .fire_pulse(fp0), .busy(busy0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full reset, released keys, then wait until both instances are back in IDLE.
    task automatic do_reset();
        rst_n  = 1'b0;
        key_in = 4'b1111;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 4'b1111;
        repeat (5) step();
        n_total++; if (sw1 !== 1'b0) $display("FAIL rst_sw: got %b want 0", sw1); else n_pass++;
        n_total++; if (key_db1 !== 4'b0000) $display("FAIL rst_key_db: got %b want 0000", key_db1);
        else n_pass++;
        n_total++; if (busy1 !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy1); else n_pass++;
        n_total++; if (fp1 !== 1'b0) $display("FAIL rst_fire: got %b want 0", fp1); else n_pass++;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i <= 2) begin
                n_total++;
                if (sw1 !== 1'b0) $display("FAIL rel_sw_low c%0d: got %b want 0", i, sw1);
                else n_pass++;
            end
            if (i == 3) begin
                n_total++; if (sw1 !== 1'b1) $display("FAIL rel_sw_high: got %b want 1", sw1);
                else n_pass++;
                n_total++; if (busy1 !== 1'b1) $display("FAIL rel_busy_hold: got %b want 1", busy1);
                else n_pass++;
            end
            if (i == 4) begin
                n_total++; if (busy1 !== 1'b0) $display("FAIL rel_busy_fall: got %b want 0", busy1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_debounce();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            key_in[0] = ((i % 4) < 2) ? 1'b0 : 1'b1;
            step();
            if (key_db1 !== 4'b0000) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL glitch_db: got %0d bad cycles want 0", bad);
        else n_pass++;
        key_in[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) begin
                n_total++;
                if (key_db1 !== 4'b0000) $display("FAIL db_early: got %b want 0000", key_db1);
                else n_pass++;
            end
            if (i == 6) begin
                n_total++;
                if (key_db1 !== 4'b0001) $display("FAIL db_accept: got %b want 0001", key_db1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_combo_fire();
        int lows = 0;
        int fires = 0;
        do_reset();
        key_in = 4'b1100;
        for (int i = 1; i <= 68; i++) begin
            step();
            case (i)
                5: begin
                    n_total++;
                    if (key_db1 !== 4'b0000) $display("FAIL cf_db_early: got %b want 0000", key_db1);
                    else n_pass++;
                end
                6: begin
                    n_total++;
                    if (key_db1 !== 4'b0011) $display("FAIL cf_db: got %b want 0011", key_db1);
                    else n_pass++;
                end
                14: begin
                    n_total++; if (sw1 !== 1'b1) $display("FAIL cf_sw_pre: got %b want 1", sw1);
                    else n_pass++;
                end
                15: begin
                    n_total++; if (sw1 !== 1'b0) $display("FAIL cf_sw_fall: got %b want 0", sw1);
                    else n_pass++;
                    n_total++; if (fp1 !== 1'b1) $display("FAIL cf_fire: got %b want 1", fp1);
                    else n_pass++;
                end
                16: begin
                    n_total++; if (fp1 !== 1'b0) $display("FAIL cf_fire_1cyc: got %b want 0", fp1);
                    else n_pass++;
                end
                17: begin
                    n_total++; if (sw1 !== 1'b0) $display("FAIL cf_sw_low3: got %b want 0", sw1);
                    else n_pass++;
                end
                18: begin
                    n_total++; if (sw1 !== 1'b1) $display("FAIL cf_sw_rise: got %b want 1", sw1);
                    else n_pass++;
                    n_total++; if (busy1 !== 1'b1) $display("FAIL cf_busy_wr: got %b want 1", busy1);
                    else n_pass++;
                end
                default: begin
                    if (i > 18) begin
                        if (sw1 === 1'b0) lows++;
                        if (fp1 === 1'b1) fires++;
                    end
                end
            endcase
        end
        n_total++; if (lows !== 0) $display("FAIL cf_retrig_sw: got %0d low cycles want 0", lows);
        else n_pass++;
        n_total++; if (fires !== 0) $display("FAIL cf_retrig_fire: got %0d pulses want 0", fires);
        else n_pass++;
        key_in = 4'b1111;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 6) begin
                n_total++; if (busy1 !== 1'b1) $display("FAIL cf_busy_rel6: got %b want 1", busy1);
                else n_pass++;
            end
            if (i == 7) begin
                n_total++; if (busy1 !== 1'b0) $display("FAIL cf_busy_rel7: got %b want 0", busy1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_partial_combo();
        int low1 = 0;
        int busy_cnt1 = 0;
        int low0 = 0;
        int fire0 = 0;
        int fall0 = 0;
        do_reset();
        key_in = 4'b1110;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (sw1 === 1'b0) low1++;
            if (busy1 === 1'b1) busy_cnt1++;
            if (sw0 === 1'b0) low0++;
            if (fp0 === 1'b1) fire0++;
            if (sw0 === 1'b0 && fall0 == 0) fall0 = i;
        end
        n_total++; if (low1 !== 0) $display("FAIL pc_m1_sw: got %0d low cycles want 0", low1);
        else n_pass++;
        n_total++; if (busy_cnt1 !== 0) $display("FAIL pc_m1_busy: got %0d busy cycles want 0",
                                               busy_cnt1);
        else n_pass++;
        n_total++; if (fall0 !== 15) $display("FAIL pc_m0_fall: got cycle %0d want 15", fall0);
        else n_pass++;
        n_total++; if (low0 !== 3) $display("FAIL pc_m0_width: got %0d want 3", low0);
        else n_pass++;
        n_total++; if (fire0 !== 1) $display("FAIL pc_m0_fire: got %0d pulses want 1", fire0);
        else n_pass++;
    endtask

    task automatic test_early_release();
        int bad = 0;
        do_reset();
        key_in = 4'b1100;
        for (int i = 1; i <= 35; i++) begin
            step();
            if (i <= 19 && (sw1 === 1'b0 || fp1 === 1'b1)) bad++;
            if (i == 6) key_in = 4'b1111;
            if (i == 12) begin
                n_total++; if (busy1 !== 1'b1) $display("FAIL er_arm: got %b want 1", busy1);
                else n_pass++;
            end
            if (i == 13) begin
                n_total++; if (busy1 !== 1'b0) $display("FAIL er_idle: got %b want 0", busy1);
                else n_pass++;
            end
            if (i == 20) key_in = 4'b1100;
            if (i == 34) begin
                n_total++; if (sw1 !== 1'b1) $display("FAIL er_refire_pre: got %b want 1", sw1);
                else n_pass++;
            end
            if (i == 35) begin
                n_total++; if (sw1 !== 1'b0) $display("FAIL er_refire_sw: got %b want 0", sw1);
                else n_pass++;
                n_total++; if (fp1 !== 1'b1) $display("FAIL er_refire_fp: got %b want 1", fp1);
                else n_pass++;
            end
        end
        n_total++; if (bad !== 0) $display("FAIL er_no_reset: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_reset_in_fire();
        int fires = 0;
        do_reset();
        key_in = 4'b1100;
        repeat (16) step();
        n_total++; if (busy1 !== 1'b1 || sw1 !== 1'b0)
            $display("FAIL rf_in_fire: got busy=%b sw=%b want busy=1 sw=0", busy1, sw1);
        else n_pass++;
        rst_n  = 1'b0;
        key_in = 4'b1111;
        #1;
        n_total++; if (key_db1 !== 4'b0000) $display("FAIL rf_async_db: got %b want 0000", key_db1);
        else n_pass++;
        n_total++; if (sw1 !== 1'b0) $display("FAIL rf_async_sw: got %b want 0", sw1); else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (fp1 === 1'b1) fires++;
            if (i == 2) begin
                n_total++; if (sw1 !== 1'b0) $display("FAIL rf_replay_low: got %b want 0", sw1);
                else n_pass++;
            end
            if (i == 3) begin
                n_total++; if (sw1 !== 1'b1) $display("FAIL rf_replay_rise: got %b want 1", sw1);
                else n_pass++;
            end
        end
        n_total++; if (fires !== 0) $display("FAIL rf_no_fire: got %0d pulses want 0", fires);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_combo_fire();
        test_partial_combo();
        test_early_release();
        test_reset_in_fire();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
